// File: rtl/stream_demux_1_2.sv
// 1-to-2 valid/ready stream demultiplexer with an independent 2-entry FIFO per output port.
// Define DEMUX_CNT_EN to add saturating 8-bit delivered-word counters (cnt0/cnt1).
module stream_demux_1_2 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sel,
    input  logic [DATA_W-1:0] in_data,
`ifdef DEMUX_CNT_EN
    output logic [7:0]        cnt0,
    output logic [7:0]        cnt1,
`endif
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_state_e;

    logic [1:0] out_ready_w;
    logic [1:0] full_w;

    assign out_ready_w = {out1_ready, out0_ready};

    // Readiness comes only from the selected FIFO's occupancy, never from downstream ready.
    assign in_ready = ~full_w[in_sel];

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        fifo_state_e       state_q, state_d;
        logic [DATA_W-1:0] head_q, head_d;
        logic [DATA_W-1:0] tail_q, tail_d;
        logic              push;
        logic              pop;

        assign push = in_valid && in_ready && (in_sel == 1'(gi));
        assign pop  = (state_q != ST_EMPTY) && out_ready_w[gi];

        always_comb begin
            state_d = state_q;
            head_d  = head_q;
            tail_d  = tail_q;
            unique case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                        head_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head_d = in_data;
                    end else if (push) begin
                        state_d = ST_FULL;
                        tail_d  = in_data;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // push cannot happen here: in_ready is low while this port is selected
                    if (pop) begin
                        state_d = ST_ONE;
                        head_d  = tail_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_EMPTY;
                head_q  <= '0;
                tail_q  <= '0;
            end else begin
                state_q <= state_d;
                head_q  <= head_d;
                tail_q  <= tail_d;
            end
        end

        assign full_w[gi] = (state_q == ST_FULL);

`ifdef DEMUX_CNT_EN
        logic [7:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (pop && (cnt_q != 8'hFF)) begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= 8'd0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
`endif
    end

    assign out0_valid = (g_port[0].state_q != ST_EMPTY);
    assign out1_valid = (g_port[1].state_q != ST_EMPTY);
    assign out0_data  = g_port[0].head_q;
    assign out1_data  = g_port[1].head_q;

`ifdef DEMUX_CNT_EN
    assign cnt0 = g_port[0].cnt_q;
    assign cnt1 = g_port[1].cnt_q;
`endif

endmodule
